dcache_responder: RTL and testbench

//   Direct-mapped, write-through, read-allocate data cache: the responder end of the
//   CPU dcache_* request interface. Serves the datapath MEM stage.

---
 rtl/dcache_pkg.sv | 49 ++++
 rtl/dcache_line_store.sv | 67 ++++++
 rtl/dcache_responder.sv | 197 +++++++++++++++++++
 tb/tb_dcache_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and address-geometry helpers for the direct-mapped data cache.
// Bus widths come from DRAM_ADDRESS_SIZE / DRAM_WORD_SIZE (default 32 bits each).
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif

package dcache_pkg;
   localparam int ADDR_W = `DRAM_ADDRESS_SIZE;
   localparam int WORD_W = `DRAM_WORD_SIZE;
   localparam int BE_W   = WORD_W / 8;

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   // Fields are full address width so one decoder serves any line geometry.
   typedef struct packed {
      logic [ADDR_W-1:0] tag;
      logic [ADDR_W-1:0] idx;
      logic [ADDR_W-1:0] woff;
      logic [ADDR_W-1:0] boff;
   } dcache_addr_t;

   function automatic int boff_bits();
      return $clog2(BE_W);
   endfunction

   function automatic int woff_bits(input int wpl);
      return $clog2(wpl);
   endfunction

   function automatic int idx_bits(input int nl);
      return $clog2(nl);
   endfunction

   function automatic int tag_bits(input int nl, input int wpl);
      return ADDR_W - boff_bits() - woff_bits(wpl) - idx_bits(nl);
   endfunction

   function automatic dcache_addr_t decode(input logic [ADDR_W-1:0] a, input int nl, input int wpl);
      dcache_addr_t d;
      d.boff = a & ADDR_W'(BE_W - 1);
      d.woff = (a >> boff_bits()) & ADDR_W'(wpl - 1);
      d.idx  = (a >> (boff_bits() + woff_bits(wpl))) & ADDR_W'(nl - 1);
      d.tag  = a >> (boff_bits() + woff_bits(wpl) + idx_bits(nl));
      return d;
   endfunction
endpackage

// File: rtl/dcache_line_store.sv
// Data, tag and valid storage for the data cache: combinational lookup,
// byte-enabled store merge, fill-word write, tag/valid set and asynchronous valid clear.
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter int TAG_W          = 26,
   parameter int IDX_W          = 4,
   parameter int WOFF_W         = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [WOFF_W-1:0] rd_woff,
   output logic [WORD_W-1:0] rd_data,
   output logic [TAG_W-1:0]  rd_tag,
   output logic              rd_valid,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [WOFF_W-1:0] wr_woff,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [BE_W-1:0]   wr_be,
   input  logic              fill_en,
   input  logic [IDX_W-1:0]  fill_idx,
   input  logic [WOFF_W-1:0] fill_woff,
   input  logic [WORD_W-1:0] fill_data,
   input  logic              tag_we,
   input  logic [IDX_W-1:0]  tag_idx,
   input  logic [TAG_W-1:0]  tag_data
);
   logic [WORD_W-1:0]    data_mem [NUM_LINES][WORDS_PER_LINE];
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_reg;
   logic [WORD_W-1:0]    old_word;
   logic [WORD_W-1:0]    merged_word;

   assign old_word = data_mem[wr_idx][wr_woff];

   for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = wr_be[gi] ? wr_data[gi*8 +: 8] : old_word[gi*8 +: 8];
   end

   always_ff @(posedge clk) begin
      if (fill_en) begin
         data_mem[fill_idx][fill_woff] <= fill_data;
      end else if (wr_en) begin
         data_mem[wr_idx][wr_woff] <= merged_word;
      end
      if (tag_we) begin
         tag_mem[tag_idx] <= tag_data;
      end
   end

   // Only the valid bits need clearing: stale data/tags are unreachable without them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_reg <= '0;
      end else if (tag_we) begin
         valid_reg[tag_idx] <= 1'b1;
      end
   end

   assign rd_data  = data_mem[rd_idx][rd_woff];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_valid = valid_reg[rd_idx];
endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, read-allocate data cache answering CPU dcache requests.
// Defining DCACHE_PERF_CNT_EN adds saturating 32-bit hit_count / miss_count outputs.
module dcache_responder
   import dcache_pkg::*;
#(
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_request,
   input  logic              cpu_rw,
   input  logic [WORD_W-1:0] cpu_writeData,
   input  logic [BE_W-1:0]   cpu_byte_en,
   output logic [WORD_W-1:0] cpu_readData,
   output logic              cpu_data_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_request,
   output logic              mem_rw,
   output logic [WORD_W-1:0] mem_writeData,
   output logic [BE_W-1:0]   mem_byte_en,
   input  logic [WORD_W-1:0] mem_readData,
   input  logic              mem_data_ready
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);
   localparam int BOFF_B = boff_bits();
   localparam int WOFF_B = woff_bits(WORDS_PER_LINE);
   localparam int IDX_B  = idx_bits(NUM_LINES);
   localparam int TAG_B  = tag_bits(NUM_LINES, WORDS_PER_LINE);
   localparam int WOFF_W = (WOFF_B > 0) ? WOFF_B : 1;
   localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(WORDS_PER_LINE - 1);

   state_t            state_reg;
   logic [WOFF_W-1:0] beat_reg;
   logic [TAG_B-1:0]  lat_tag_reg;
   logic [IDX_B-1:0]  lat_idx_reg;
   logic [WOFF_W-1:0] lat_woff_reg;
   logic              lat_hit_reg;
   logic              write_done_reg;

   dcache_addr_t      cpu_dec;
   logic [TAG_B-1:0]  cpu_tag;
   logic [IDX_B-1:0]  cpu_idx;
   logic [WOFF_W-1:0] cpu_woff;
   logic              unused_dec_bits;
   logic [WORD_W-1:0] rd_data;
   logic [TAG_B-1:0]  rd_tag;
   logic              rd_valid;
   logic              hit;
   logic              start_fill;
   logic              start_write;
   logic              fill_beat;
   logic              fill_last;
   logic              store_ack;

   function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_B-1:0] t,
                                                   input logic [IDX_B-1:0] i,
                                                   input logic [WOFF_W-1:0] k);
      return (ADDR_W'(t) << (IDX_B + WOFF_B + BOFF_B)) |
             (ADDR_W'(i) << (WOFF_B + BOFF_B)) |
             (ADDR_W'(k) << BOFF_B);
   endfunction

   assign cpu_dec  = decode(cpu_address, NUM_LINES, WORDS_PER_LINE);
   assign cpu_tag  = cpu_dec.tag[TAG_B-1:0];
   assign cpu_idx  = cpu_dec.idx[IDX_B-1:0];
   assign cpu_woff = cpu_dec.woff[WOFF_W-1:0];
   assign unused_dec_bits = ^{cpu_dec.tag[ADDR_W-1:TAG_B], cpu_dec.idx[ADDR_W-1:IDX_B],
                              cpu_dec.woff[ADDR_W-1:WOFF_W], cpu_dec.boff};

   assign hit = rd_valid && (rd_tag == cpu_tag);
   // The cycle after a store retires must not relaunch the still-held request.
   assign start_write = (state_reg == IDLE) && cpu_request && !write_done_reg && cpu_rw;
   assign start_fill  = (state_reg == IDLE) && cpu_request && !write_done_reg && !cpu_rw && !hit;
   assign fill_beat   = (state_reg == FILL) && mem_data_ready;
   assign fill_last   = fill_beat && (beat_reg == LAST_BEAT);
   assign store_ack   = (state_reg == WRITE) && mem_data_ready;

   assign cpu_data_ready = write_done_reg ||
                           ((state_reg == IDLE) && (!cpu_request || (!cpu_rw && hit)));
   assign cpu_readData   = ((state_reg == IDLE) && hit) ? rd_data : '0;

   dcache_line_store #(
      .NUM_LINES      (NUM_LINES),
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .TAG_W          (TAG_B),
      .IDX_W          (IDX_B),
      .WOFF_W         (WOFF_W)
   ) u_store (
      .clk       (clk),
      .reset     (reset),
      .rd_idx    (cpu_idx),
      .rd_woff   (cpu_woff),
      .rd_data   (rd_data),
      .rd_tag    (rd_tag),
      .rd_valid  (rd_valid),
      .wr_en     (store_ack && lat_hit_reg),
      .wr_idx    (lat_idx_reg),
      .wr_woff   (lat_woff_reg),
      .wr_data   (mem_writeData),
      .wr_be     (mem_byte_en),
      .fill_en   (fill_beat),
      .fill_idx  (lat_idx_reg),
      .fill_woff (beat_reg),
      .fill_data (mem_readData),
      .tag_we    (fill_last),
      .tag_idx   (lat_idx_reg),
      .tag_data  (lat_tag_reg)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         beat_reg       <= '0;
         lat_tag_reg    <= '0;
         lat_idx_reg    <= '0;
         lat_woff_reg   <= '0;
         lat_hit_reg    <= 1'b0;
         write_done_reg <= 1'b0;
         mem_address    <= '0;
         mem_request    <= 1'b0;
         mem_rw         <= 1'b0;
         mem_writeData  <= '0;
         mem_byte_en    <= '0;
      end else begin
         write_done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start_write) begin
                  state_reg     <= WRITE;
                  lat_idx_reg   <= cpu_idx;
                  lat_woff_reg  <= cpu_woff;
                  lat_hit_reg   <= hit;
                  mem_address   <= cpu_address & ~ADDR_W'(BE_W - 1);
                  mem_request   <= 1'b1;
                  mem_rw        <= 1'b1;
                  mem_writeData <= cpu_writeData;
                  mem_byte_en   <= cpu_byte_en;
               end else if (start_fill) begin
                  state_reg   <= FILL;
                  beat_reg    <= '0;
                  lat_tag_reg <= cpu_tag;
                  lat_idx_reg <= cpu_idx;
                  mem_address <= line_addr(cpu_tag, cpu_idx, '0);
                  mem_request <= 1'b1;
                  mem_rw      <= 1'b0;
               end
            end
            FILL: begin
               if (fill_last) begin
                  state_reg   <= IDLE;
                  mem_request <= 1'b0;
               end else if (fill_beat) begin
                  beat_reg    <= beat_reg + WOFF_W'(1);
                  mem_address <= line_addr(lat_tag_reg, lat_idx_reg, beat_reg + WOFF_W'(1));
               end
            end
            WRITE: begin
               if (store_ack) begin
                  state_reg      <= IDLE;
                  mem_request    <= 1'b0;
                  mem_rw         <= 1'b0;
                  write_done_reg <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   // The retried lookup right after a fill belongs to that miss, not to the hit count.
   logic fill_done_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fill_done_reg <= 1'b0;
         hit_count     <= '0;
         miss_count    <= '0;
      end else begin
         fill_done_reg <= fill_last;
         if ((state_reg == IDLE) && cpu_request && !cpu_rw && hit && !fill_done_reg &&
             (hit_count != '1)) begin
            hit_count <= hit_count + 32'd1;
         end
         if (start_fill && (miss_count != '1)) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: directed CPU accesses against a small DRAM model.
module tb_dcache_responder;
   import dcache_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [ADDR_W-1:0] cpu_address;
   logic              cpu_request;
   logic              cpu_rw;
   logic [WORD_W-1:0] cpu_writeData;
   logic [BE_W-1:0]   cpu_byte_en;
   logic [WORD_W-1:0] cpu_readData;
   logic              cpu_data_ready;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_request;
   logic              mem_rw;
   logic [WORD_W-1:0] mem_writeData;
   logic [BE_W-1:0]   mem_byte_en;
   logic [WORD_W-1:0] mem_readData;
   logic              mem_data_ready;
`ifdef DCACHE_PERF_CNT_EN
   logic [31:0]       hit_count;
   logic [31:0]       miss_count;
`endif

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic              rw;
      logic [WORD_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } mem_txn_t;

   typedef struct {
      logic              rw;
      logic [WORD_W-1:0] data;
   } cpu_txn_t;

   mem_txn_t          exp_mem[$];
   cpu_txn_t          exp_cpu[$];
   logic [WORD_W-1:0] dram [logic [ADDR_W-1:0]];
   int                n_cmp = 0;
   int                n_fail = 0;
   int                mem_seen = 0;
   longint            last_rdy_t = 0;

   always #5 clk = ~clk;

   dcache_responder dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_address    (cpu_address),
      .cpu_request    (cpu_request),
      .cpu_rw         (cpu_rw),
      .cpu_writeData  (cpu_writeData),
      .cpu_byte_en    (cpu_byte_en),
      .cpu_readData   (cpu_readData),
      .cpu_data_ready (cpu_data_ready),
      .mem_address    (mem_address),
      .mem_request    (mem_request),
      .mem_rw         (mem_rw),
      .mem_writeData  (mem_writeData),
      .mem_byte_en    (mem_byte_en),
      .mem_readData   (mem_readData),
      .mem_data_ready (mem_data_ready)
`ifdef DCACHE_PERF_CNT_EN
      ,
      .hit_count      (hit_count),
      .miss_count     (miss_count)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   function automatic logic [WORD_W-1:0] dram_rd(input logic [ADDR_W-1:0] a);
      if (dram.exists(a)) return dram[a];
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic exp_reads(input logic [ADDR_W-1:0] base, input int beats);
      mem_txn_t t;
      for (int k = 0; k < beats; k++) begin
         t.addr = base + ADDR_W'(4 * k);
         t.rw = 1'b0;
         t.wdata = '0;
         t.be = '0;
         exp_mem.push_back(t);
      end
   endtask

   task automatic exp_write(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d, input logic [BE_W-1:0] be);
      mem_txn_t t;
      t.addr = a;
      t.rw = 1'b1;
      t.wdata = d;
      t.be = be;
      exp_mem.push_back(t);
   endtask

   // DRAM: one response per access, a cycle after the request is seen.
   initial begin
      mem_data_ready = 1'b0;
      mem_readData = '0;
      forever begin
         @(negedge clk);
         if (reset && mem_request) begin
            mem_txn_t got;
            mem_txn_t e;
            got.addr = mem_address;
            got.rw = mem_rw;
            got.wdata = mem_writeData;
            got.be = mem_byte_en;
            mem_seen++;
            if (exp_mem.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL mem_unexpected: got addr %h rw %b, required no access", got.addr, got.rw);
            end else begin
               e = exp_mem.pop_front();
               check("mem_addr", got.addr, e.addr);
               check("mem_rw", 32'(got.rw), 32'(e.rw));
               if (e.rw) begin
                  check("mem_wdata", got.wdata, e.wdata);
                  check("mem_byte_en", 32'(got.be), 32'(e.be));
               end
            end
            @(negedge clk);
            if (reset && mem_request) begin
               if (got.rw) begin
                  logic [WORD_W-1:0] w;
                  w = dram_rd(got.addr);
                  for (int b = 0; b < BE_W; b++)
                     if (got.be[b]) w[b*8 +: 8] = got.wdata[b*8 +: 8];
                  dram[got.addr] = w;
                  mem_readData = '0;
               end else begin
                  mem_readData = dram_rd(got.addr);
               end
               mem_data_ready = 1'b1;
               last_rdy_t = longint'($time);
               @(negedge clk);
               mem_data_ready = 1'b0;
            end
         end
      end
   end

   // CPU-side monitor: every served request pops one expected response.
   initial begin
      forever begin
         @(negedge clk);
         if (reset && cpu_request && cpu_data_ready) begin
            cpu_txn_t c;
            if (exp_cpu.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL cpu_unexpected: got response at addr %h, required none", cpu_address);
            end else begin
               c = exp_cpu.pop_front();
               if (!c.rw) check($sformatf("cpu_readData@%h", cpu_address), cpu_readData, c.data);
            end
         end
      end
   end

   task automatic cpu_access(input logic [ADDR_W-1:0] a, input logic rw, input logic [WORD_W-1:0] wd,
                             input logic [BE_W-1:0] be, input logic [WORD_W-1:0] exp_rd, input int exp_lat);
      cpu_txn_t c;
      int       cyc;
      bit       served;
      cyc = 0;
      served = 0;
      c.rw = rw;
      c.data = exp_rd;
      exp_cpu.push_back(c);
      @(posedge clk);
      #1;
      cpu_address = a;
      cpu_rw = rw;
      cpu_writeData = wd;
      cpu_byte_en = be;
      cpu_request = 1'b1;
      while (!served && cyc < 200) begin
         @(negedge clk);
         if (cpu_data_ready) served = 1;
         else cyc++;
      end
      if (!served) begin
         n_cmp++;
         n_fail++;
         $display("FAIL cpu_timeout: addr %h not served after %0d cycles, required service", a, cyc);
         exp_cpu.delete();
      end else begin
         if (exp_lat >= 0) check($sformatf("latency@%h", a), 32'(cyc), 32'(exp_lat));
         if (rw) check($sformatf("store_ack_delay@%h", a), 32'(longint'($time) - last_rdy_t), 32'd10);
      end
      @(posedge clk);
      #1;
      cpu_request = 1'b0;
      check($sformatf("mem_pending@%h", a), 32'(exp_mem.size()), 32'd0);
      exp_mem.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int cyc;
      cpu_request = 1'b0;
      cpu_address = '0;
      cpu_rw = 1'b0;
      cpu_writeData = '0;
      cpu_byte_en = '0;
      dram[32'h040] = 32'h11;
      dram[32'h044] = 32'h22;
      dram[32'h048] = 32'h33;
      dram[32'h04C] = 32'h44;

      // 1: reset state
      repeat (3) @(negedge clk);
      check("rst_mem_request", 32'(mem_request), 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      check("rst_mem_rw", 32'(mem_rw), 32'd0);
      check("rst_cpu_readData", cpu_readData, 32'd0);
      check("rst_cpu_data_ready", 32'(cpu_data_ready), 32'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("idle_cpu_data_ready", 32'(cpu_data_ready), 32'd1);
      check("idle_mem_request", 32'(mem_request), 32'd0);
      check("idle_valid_bits", 32'(dut.u_store.valid_reg), 32'd0);

      // 2: cold read fill, then a zero-latency hit
      exp_reads(32'h040, 4);
      cpu_access(32'h040, 1'b0, '0, '0, 32'h11, -1);
      cpu_access(32'h048, 1'b0, '0, '0, 32'h33, 0);
`ifdef DCACHE_PERF_CNT_EN
      check("hit_count", hit_count, 32'd1);
      check("miss_count", miss_count, 32'd1);
`endif

      // 3: partial store hit
      exp_write(32'h044, 32'hAABBCCDD, 4'b0011);
      cpu_access(32'h044, 1'b1, 32'hAABBCCDD, 4'b0011, '0, -1);
      cpu_access(32'h044, 1'b0, '0, '0, 32'h0000CCDD, 0);

      // 4: store miss does not allocate
      exp_write(32'h400, 32'h12345678, 4'b1111);
      cpu_access(32'h400, 1'b1, 32'h12345678, 4'b1111, '0, -1);
      exp_reads(32'h400, 4);
      cpu_access(32'h400, 1'b0, '0, '0, 32'h12345678, -1);
      cpu_access(32'h404, 1'b0, '0, '0, 32'hA5A50404, 0);

      // 5: index conflict between 0x040 and 0x440
      cpu_access(32'h040, 1'b0, '0, '0, 32'h11, 0);
      exp_reads(32'h440, 4);
      cpu_access(32'h440, 1'b0, '0, '0, 32'hA5A50440, -1);
      exp_reads(32'h040, 4);
      cpu_access(32'h040, 1'b0, '0, '0, 32'h11, -1);
      cpu_access(32'h044, 1'b0, '0, '0, 32'h0000CCDD, 0);

      // store with no lanes still reaches DRAM and changes nothing
      exp_write(32'h048, 32'hFFFFFFFF, 4'b0000);
      cpu_access(32'h048, 1'b1, 32'hFFFFFFFF, 4'b0000, '0, -1);
      cpu_access(32'h048, 1'b0, '0, '0, 32'h33, 0);

      // 6: asynchronous reset during beat 2 of a fill
      exp_reads(32'h0C0, 3);
      @(posedge clk);
      #1;
      base = mem_seen;
      cpu_address = 32'h0C0;
      cpu_rw = 1'b0;
      cpu_request = 1'b1;
      cyc = 0;
      while (mem_seen < base + 3 && cyc < 200) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check("beat2_reached", 32'(mem_seen - base), 32'd3);
      #1 reset = 1'b0;
      #1;
      check("async_rst_mem_request", 32'(mem_request), 32'd0);
      check("async_rst_valid_bits", 32'(dut.u_store.valid_reg), 32'd0);
      cpu_request = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      check("aborted_fill_pending", 32'(exp_mem.size()), 32'd0);
      exp_mem.delete();
      exp_reads(32'h0C0, 4);
      cpu_access(32'h0C0, 1'b0, '0, '0, 32'hA5A500C0, -1);

      repeat (5) @(posedge clk);
      check("cpu_pending", 32'(exp_cpu.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
